// File: rtl/accumulator_sequencer.sv
// Accumulator sequencer: drives the external 8-bit adder_subtractor and folds its result into an accumulator.
// Optional build macro ACC_SATURATION_EN clamps ADD/SUB results on signed overflow instead of wrapping.
module accumulator_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] factor_a,
  output logic [WIDTH-1:0] factor_b,
  output logic             operation,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] accumulator,
  output logic             done,
  output logic             flag_zero,
  output logic             flag_negative,
  output logic             flag_overflow
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] fb_q, fb_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;

  logic             a_msb, b_msb, r_msb;
  logic             arith_ovf;
  logic [WIDTH-1:0] arith_val;

  assign a_msb = acc_q[WIDTH-1];
  assign b_msb = fb_q[WIDTH-1];
  assign r_msb = result[WIDTH-1];

  // Subtraction overflows only when the operand signs differ; addition only when they match.
  assign arith_ovf = (sub_q ? (a_msb != b_msb) : (a_msb == b_msb)) && (r_msb != a_msb);

`ifdef ACC_SATURATION_EN
  logic [WIDTH-1:0] sat_val;
  assign sat_val   = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign arith_val = arith_ovf ? sat_val : result;
`else
  assign arith_val = result;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fb_d    = fb_q;
    sub_d   = sub_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          fb_d    = cmd_data;
          sub_d   = (cmd_op == OP_SUB);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_LOAD:  begin acc_d = fb_q;      ovf_d = 1'b0;      end
          OP_ADD,
          OP_SUB:   begin acc_d = arith_val; ovf_d = arith_ovf; end
          OP_CLEAR: begin acc_d = '0;        ovf_d = 1'b0;      end
          default:  begin acc_d = acc_q;     ovf_d = ovf_q;     end
        endcase
        state_d = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_LOAD;
      fb_q    <= '0;
      sub_q   <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fb_q    <= fb_d;
      sub_q   <= sub_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cmd_ready     = (state_q == S_IDLE);
  assign done          = (state_q == S_WRITE);
  assign factor_a      = acc_q;
  assign factor_b      = fb_q;
  assign operation     = sub_q;
  assign accumulator   = acc_q;
  assign flag_zero     = (acc_q == '0);
  assign flag_negative = acc_q[WIDTH-1];
  assign flag_overflow = ovf_q;

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Directed bench for accumulator_sequencer with a behavioural adder_subtractor model on the operand bus.
module tb_accumulator_sequencer;

  logic       clock;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] factor_a;
  logic [7:0] factor_b;
  logic       operation;
  logic [7:0] result;
  logic [7:0] accumulator;
  logic       done;
  logic       flag_zero;
  logic       flag_negative;
  logic       flag_overflow;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] prev_acc = 8'h00;

  accumulator_sequencer #(.WIDTH(8)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_data      (cmd_data),
    .factor_a      (factor_a),
    .factor_b      (factor_b),
    .operation     (operation),
    .result        (result),
    .accumulator   (accumulator),
    .done          (done),
    .flag_zero     (flag_zero),
    .flag_negative (flag_negative),
    .flag_overflow (flag_overflow)
  );

  // Adder stage model: combinational, wraps modulo 256.
  assign result = operation ? (factor_a - factor_b) : (factor_a + factor_b);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d,
                         input logic [7:0] exp_acc, input logic exp_ovf);
    @(negedge clock);
    chk("ready_idle", {7'd0, cmd_ready}, 8'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    cmd_data  = 8'hAA;
    @(negedge clock);
    chk("exec_ready",  {7'd0, cmd_ready}, 8'd0);
    chk("exec_done",   {7'd0, done}, 8'd0);
    chk("exec_fa",     factor_a, prev_acc);
    chk("exec_fb",     factor_b, d);
    chk("exec_op",     {7'd0, operation}, {7'd0, (op == 2'b10)});
    @(negedge clock);
    chk("wr_done",     {7'd0, done}, 8'd1);
    chk("wr_ready",    {7'd0, cmd_ready}, 8'd0);
    chk("wr_acc",      accumulator, exp_acc);
    chk("wr_ovf",      {7'd0, flag_overflow}, {7'd0, exp_ovf});
    chk("wr_zero",     {7'd0, flag_zero}, {7'd0, (exp_acc == 8'h00)});
    chk("wr_neg",      {7'd0, flag_negative}, {7'd0, exp_acc[7]});
    prev_acc = exp_acc;
    @(negedge clock);
    chk("post_done",   {7'd0, done}, 8'd0);
    chk("post_ready",  {7'd0, cmd_ready}, 8'd1);
    chk("post_acc",    accumulator, exp_acc);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_acc",   accumulator, 8'h00);
    chk("rst_zero",  {7'd0, flag_zero}, 8'd1);
    chk("rst_neg",   {7'd0, flag_negative}, 8'd0);
    chk("rst_ovf",   {7'd0, flag_overflow}, 8'd0);
    chk("rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("rst_done",  {7'd0, done}, 8'd0);
    chk("rst_fb",    factor_b, 8'h00);
    chk("rst_op",    {7'd0, operation}, 8'd0);

    run_cmd(2'b00, 8'h05, 8'h05, 1'b0);
    run_cmd(2'b01, 8'h03, 8'h08, 1'b0);
    run_cmd(2'b10, 8'h0A, 8'hFE, 1'b0);

    run_cmd(2'b00, 8'h7F, 8'h7F, 1'b0);
`ifdef ACC_SATURATION_EN
    run_cmd(2'b01, 8'h01, 8'h7F, 1'b1);
`else
    run_cmd(2'b01, 8'h01, 8'h80, 1'b1);
`endif

    run_cmd(2'b00, 8'h80, 8'h80, 1'b0);
`ifdef ACC_SATURATION_EN
    run_cmd(2'b10, 8'h01, 8'h80, 1'b1);
`else
    run_cmd(2'b10, 8'h01, 8'h7F, 1'b1);
`endif
    run_cmd(2'b11, 8'h55, 8'h00, 1'b0);

    // 0 - (-128): adder yields 0x80, signs differ and result sign flips.
`ifdef ACC_SATURATION_EN
    run_cmd(2'b10, 8'h80, 8'h7F, 1'b1);
`else
    run_cmd(2'b10, 8'h80, 8'h80, 1'b1);
`endif
    run_cmd(2'b00, 8'h20, 8'h20, 1'b0);

    // Abort an ADD during its EXEC cycle.
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 8'h10;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    chk("abort_exec_fa", factor_a, 8'h20);
    chk("abort_exec_rdy", {7'd0, cmd_ready}, 8'd0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("abort_acc",  accumulator, 8'h00);
    chk("abort_done", {7'd0, done}, 8'd0);
    chk("abort_zero", {7'd0, flag_zero}, 8'd1);
    chk("abort_fb",   factor_b, 8'h00);
    @(negedge clock);
    reset_n = 1'b1;
    chk("abort_rel_ready", {7'd0, cmd_ready}, 8'd1);
    chk("abort_rel_done",  {7'd0, done}, 8'd0);
    @(negedge clock);
    chk("abort_nodone", {7'd0, done}, 8'd0);
    chk("abort_acc2",   accumulator, 8'h00);
    prev_acc = 8'h00;

    run_cmd(2'b01, 8'h10, 8'h10, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/accumulator_sequencer.md
Name: accumulator_sequencer

Overview:
- Downstream consumer and upstream driver of the 8-bit adder_subtractor stage.
- Accepts LOAD/ADD/SUB/CLEAR commands over a valid/ready handshake.
- Presents registered operands and the operation bit to the adder, then latches the adder result into an 8-bit accumulator.
- Produces signed status flags (zero, negative, overflow) and a one-cycle done pulse for the register-file logic.

Parameters:
- WIDTH, 8, datapath width; fixed to match the adder stage, other values unsupported.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR.
- cmd_data  input  WIDTH  operand (ignored for CLEAR).
- factor_a  output  WIDTH  to adder: current accumulator.
- factor_b  output  WIDTH  to adder: latched operand.
- operation  output  1  to adder: 0 add, 1 subtract.
- result  input  WIDTH  from adder: factor_a ± factor_b, combinational.
- accumulator  output  WIDTH  current accumulator value.
- done  output  1  one-cycle pulse when the accumulator has been updated.
- flag_zero  output  1  accumulator == 0.
- flag_negative  output  1  accumulator bit 7.
- flag_overflow  output  1  signed overflow on the last ADD/SUB.

Behaviour:
- Reset (async, reset_n low):
  - State IDLE.
  - accumulator, factor_b = 0; operation = 0.
  - done, flag_overflow = 0; flag_zero = 1; flag_negative = 0.
  - cmd_ready = 1 once reset is released.
  - Reset asserted mid-operation aborts the command with no writeback.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready at edge N:
    - cmd_op, cmd_data are latched; factor_b <= cmd_data; operation <= (cmd_op == SUB).
    - Next state is EXEC.
  - EXEC (cycle N+1): cmd_ready = 0. Adder inputs are stable for the full cycle. At edge N+2 the accumulator is written:
    - LOAD: cmd_data.
    - ADD/SUB: result.
    - CLEAR: 0.
    - Next state is WRITE.
  - WRITE (cycle N+2): done = 1 for exactly one cycle; cmd_ready = 0. Next state is IDLE.
- Throughput: one command per 3 cycles. The cmd_valid/cmd_data values held while cmd_ready = 0 are ignored; the source must hold them until the handshake completes.
- factor_a is continuously equal to accumulator.
- Flags:
  - flag_zero and flag_negative are combinational from the accumulator.
  - flag_overflow is registered at the writeback edge:
    - ADD: (a[7] == b[7]) && (r[7] != a[7]).
    - SUB: (a[7] != b[7]) && (r[7] != a[7]).
    - LOAD/CLEAR: 0.
  - Here a = accumulator before the update, b = factor_b, r = result.
- Wrap-around: without the optional feature, the result wraps modulo 2^8 (two's complement).
- Edge operand: SUB with b = -128 (0x80) follows the adder's behaviour (negation of 0x80 is 0x80); the overflow formula above still applies.
- Undefined cmd_op values do not exist (2-bit field fully decoded).

Optional Feature:
- Macro: ACC_SATURATION_EN.
- Defined: on ADD/SUB with signed overflow, the accumulator is clamped instead of taking result:
  - 0x7F if a[7] == 0.
  - 0x80 if a[7] == 1.
  - flag_overflow is still set to 1.
- Undefined: the accumulator takes result unconditionally (wrap).

Test Plan:
- Reset released, no commands -> accumulator 0x00, flag_zero 1, cmd_ready 1, done 0.
- LOAD 0x05 at edge N -> accumulator 0x05 after edge N+2, done high only in cycle N+2, cmd_ready low in cycles N+1 and N+2.
- LOAD 0x05, ADD 0x03, SUB 0x0A -> accumulator 0x08 then 0xFE; flag_negative 1; flag_overflow 0; factor_a/factor_b/operation = 0x08/0x0A/1 during the SUB EXEC cycle.
- LOAD 0x7F, ADD 0x01 -> without ACC_SATURATION_EN: accumulator 0x80, flag_overflow 1. With ACC_SATURATION_EN: accumulator 0x7F, flag_overflow 1.
- LOAD 0x80, SUB 0x01 -> wrap: 0x7F, overflow 1; saturate: 0x80, overflow 1. Then CLEAR -> 0x00, flag_zero 1, overflow 0.
- Reset pulsed during EXEC of ADD 0x10 on accumulator 0x20 -> accumulator 0x00, no done pulse, IDLE with cmd_ready 1 after release.
